// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter and three-phase strobe sequencer for a bank of D latches.
// It is the only driver of the bank's data bus and one-hot enables. Every output is registered.
module latch_bank_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int AW    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*AW-1:0]   i_wr_addr,
  input  logic [N_REQ*DW-1:0]   i_wr_data,
  output logic [N_REQ-1:0]      o_ack,
  output logic                  o_busy,
  output logic [DW-1:0]         o_lat_d,
  output logic [(2**AW)-1:0]    o_lat_en,
  output logic [1:0]            o_state
);

  // Handshake: requester i holds i_req[i], its address and its data stable until the
  // cycle o_ack[i] is high. It drops i_req[i] on the following edge unless it has
  // another write ready. Address and data are captured at grant, so later input
  // changes never reach the write in flight.

  localparam int NE = 2**AW;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       r_gnt;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_lat_d;
  logic [NE-1:0]       r_lat_en;
  logic [N_REQ-1:0]    r_ack;
  logic                r_busy;

  logic [N_REQ-1:0]    w_elig;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       w_win;
  logic                w_found;
  logic                w_grant;
  logic [PW-1:0]       w_next_ptr;
  logic [NE-1:0]       w_en_dec;
  logic [N_REQ-1:0]    w_ack_dec;

  // r_ack is nonzero only in HOLD, so masking with it excludes the requester just served.
  assign w_elig = i_req & ~r_ack;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);
    end
  end

  assign w_grant    = w_found && ((r_state == S_IDLE) || (r_state == S_HOLD));
  assign w_next_ptr = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + PW'(1);
  assign w_en_dec   = NE'(1) << r_addr;
  assign w_ack_dec  = N_REQ'(1) << r_gnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_grant ? S_SETUP : S_IDLE;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = S_HOLD;
      S_HOLD:   w_next = w_grant ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_addr   <= '0;
      r_lat_d  <= '0;
      r_lat_en <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt    <= w_win;
        r_addr   <= i_wr_addr[w_win*AW +: AW];
        r_lat_d  <= i_wr_data[w_win*DW +: DW];
        r_rr_ptr <= w_next_ptr;
      end
      // Enable opens only for the cycle after SETUP, ack fires only for the cycle after STROBE.
      r_lat_en <= (r_state == S_SETUP) ? w_en_dec : '0;
      r_ack    <= (r_state == S_STROBE) ? w_ack_dec : '0;
      r_busy   <= (w_next != S_IDLE);
    end
  end

  assign o_ack    = r_ack;
  assign o_busy   = r_busy;
  assign o_lat_d  = r_lat_d;
  assign o_lat_en = r_lat_en;
  assign o_state  = r_state;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter: directed scenarios plus a scoreboard of expected
// {ack, enable, data} triples checked whenever a write completes.
module tb_latch_bank_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    ack;
  logic            busy;
  logic [DW-1:0]   lat_d;
  logic [3:0]      lat_en;
  logic [1:0]      state;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_e;
  logic [15:0] got_e;
  logic [3:0]  mon_en;
  logic [7:0]  mon_d;
  logic [7:0]  mem [4];

  latch_bank_write_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_ack(ack), .o_busy(busy), .o_lat_d(lat_d), .o_lat_en(lat_en), .o_state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural level-sensitive latch bank
  always @(lat_en or lat_d) begin
    for (int j = 0; j < 4; j++) if (lat_en[j]) mem[j] = lat_d;
  end

  // scoreboard: remember the strobe, compare when the ack appears
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_en != 4'b0) begin
        mon_en = lat_en;
        mon_d  = lat_d;
      end
      if (ack != 4'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_ack got ack=%b exp none", ack);
        end else begin
          exp_e = exp_q.pop_front();
          got_e = {ack, mon_en, mon_d};
          if (got_e !== exp_e) begin
            bad++;
            $display("FAIL sb_write got=%h exp=%h", got_e, exp_e);
          end
        end
        total++;
        if (lat_d !== mon_d) begin
          bad++;
          $display("FAIL hold_data_stable got=%h exp=%h", lat_d, mon_d);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int i);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (ack[i] !== 1'b1 && cnt < 40);
    total++;
    if (ack[i] !== 1'b1) begin
      bad++;
      $display("FAIL ack_timeout req=%0d got=%b exp=1", i, ack[i]);
    end
  endtask

  task automatic requester(input int i, input int n, input logic [1:0] a, input logic [7:0] base);
    @(negedge clk);
    for (int w = 0; w < n; w++) begin
      wr_addr[i*AW +: AW] = a;
      wr_data[i*DW +: DW] = base + 8'(w);
      req[i] = 1'b1;
      wait_ack(i);
    end
    req[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    outs = {ack, lat_en, lat_d};
    total++;
    if (outs !== 16'h0 || busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_values got=%h busy=%b st=%0d exp=0", outs, busy, state);
    end
    @(negedge clk);
    rst = 1'b0;
    wr_addr[0 +: AW] = 2'd2;
    wr_data[0 +: DW] = 8'h3C;
    req[0] = 1'b1;
    @(negedge clk);
    total++;
    if (lat_d !== 8'h3C) begin
      bad++;
      $display("FAIL reset_pre_setup got=%h exp=3c", lat_d);
    end
    #1 rst = 1'b1;
    #1;
    outs = {ack, lat_en, lat_d};
    total++;
    if (outs !== 16'h0 || busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_async got=%h busy=%b st=%0d exp=0", outs, busy, state);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (lat_en !== 4'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c=%0d got en=%b busy=%b exp 0", c, lat_en, busy);
      end
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    wr_addr[2*AW +: AW] = 2'd1;
    wr_data[2*DW +: DW] = 8'hA5;
    req[2] = 1'b1;
    exp_q.push_back({4'b0100, 4'b0010, 8'hA5});
    @(negedge clk);
    total++;
    if (lat_d !== 8'hA5 || lat_en !== 4'b0 || busy !== 1'b1 || state !== 2'd1) begin
      bad++;
      $display("FAIL single_setup got d=%h en=%b busy=%b st=%0d exp a5/0000/1/1", lat_d, lat_en, busy, state);
    end
    @(negedge clk);
    total++;
    if (lat_en !== 4'b0010 || ack !== 4'b0 || lat_d !== 8'hA5) begin
      bad++;
      $display("FAIL single_strobe got en=%b ack=%b exp 0010/0000", lat_en, ack);
    end
    @(negedge clk);
    total++;
    if (ack !== 4'b0100 || lat_en !== 4'b0 || lat_d !== 8'hA5) begin
      bad++;
      $display("FAIL single_hold got ack=%b en=%b d=%h exp 0100/0000/a5", ack, lat_en, lat_d);
    end
    req[2] = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ack !== 4'b0 || mem[1] !== 8'hA5) begin
      bad++;
      $display("FAIL single_after got busy=%b ack=%b mem1=%h exp 0/0000/a5", busy, ack, mem[1]);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ack;
    do_reset();
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = AW'(i);
      wr_data[i*DW +: DW] = 8'h10 + 8'(i);
      exp_q.push_back({4'(1 << i), 4'(1 << i), 8'h10 + 8'(i)});
    end
    req = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_ack = (c % 3 == 0) ? 4'(1 << (c / 3 - 1)) : 4'b0;
      total++;
      if (busy !== 1'b1 || ack !== exp_ack) begin
        bad++;
        $display("FAIL contention c=%0d got busy=%b ack=%b exp 1/%b", c, busy, ack, exp_ack);
      end
      req = req & ~ack;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL contention_end got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    exp_q.push_back({4'b0001, 4'b0001, 8'h20});
    exp_q.push_back({4'b1000, 4'b1000, 8'h30});
    exp_q.push_back({4'b0001, 4'b0001, 8'h21});
    exp_q.push_back({4'b1000, 4'b1000, 8'h31});
    fork
      requester(0, 2, 2'd0, 8'h20);
      requester(3, 2, 2'd3, 8'h30);
    join
    repeat (2) @(negedge clk);
    total++;
    if (mem[3] !== 8'h31 || mem[0] !== 8'h21) begin
      bad++;
      $display("FAIL fairness_mem got m0=%h m3=%h exp 21/31", mem[0], mem[3]);
    end
  endtask

  task automatic test_data_isolation();
    do_reset();
    wr_addr[1*AW +: AW] = 2'd2;
    wr_data[1*DW +: DW] = 8'h5C;
    req[1] = 1'b1;
    exp_q.push_back({4'b0010, 4'b0100, 8'h5C});
    repeat (2) @(negedge clk);
    total++;
    if (lat_en !== 4'b0100) begin
      bad++;
      $display("FAIL iso_strobe got en=%b exp 0100", lat_en);
    end
    wr_data[1*DW +: DW] = 8'hFF;
    wr_addr[1*AW +: AW] = 2'd0;
    @(negedge clk);
    total++;
    if (lat_d !== 8'h5C || ack !== 4'b0010) begin
      bad++;
      $display("FAIL iso_hold got d=%h ack=%b exp 5c/0010", lat_d, ack);
    end
    req[1] = 1'b0;
    @(negedge clk);
    total++;
    if (mem[2] !== 8'h5C || mem[0] !== 8'h21) begin
      bad++;
      $display("FAIL iso_mem got m2=%h m0=%h exp 5c/21", mem[2], mem[0]);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    wr_addr[1*AW +: AW] = 2'd1;
    wr_data[1*DW +: DW] = 8'h66;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (lat_en !== 4'b0010) begin
      bad++;
      $display("FAIL rmw_strobe got en=%b exp 0010", lat_en);
    end
    wr_addr[3*AW +: AW] = 2'd3;
    wr_data[3*DW +: DW] = 8'h77;
    req[3] = 1'b1;
    #1 rst = 1'b1;
    #1;
    total++;
    if (lat_en !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmw_async got en=%b ack=%b busy=%b exp 0", lat_en, ack, busy);
    end
    @(negedge clk);
    total++;
    if (ack !== 4'b0) begin
      bad++;
      $display("FAIL rmw_no_ack got ack=%b exp 0000", ack);
    end
    exp_q.push_back({4'b0010, 4'b0010, 8'h66});
    exp_q.push_back({4'b1000, 4'b1000, 8'h77});
    rst = 1'b0;
    fork
      begin wait_ack(1); req[1] = 1'b0; end
      begin wait_ack(3); req[3] = 1'b0; end
    join
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_data_isolation();
    test_reset_mid_write();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
